// File: rtl/pwm_meas.sv
// rtl/pwm_meas.sv - PWM period / high-time meter with stuck-input timeout
module pwm_meas #(
    parameter int SYSCLK_FRQ = 50000000,
    parameter int freq_min   = 1,
    parameter int MAX_CNT    = SYSCLK_FRQ / freq_min,
    parameter int NBITS      = $clog2(MAX_CNT + 1)
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iPWM,
    output logic [NBITS-1:0] oPERIOD,
    output logic [NBITS-1:0] oHIGH,
    output logic             oVALID,
    output logic             oTIMEOUT,
    output logic             oLEVEL
);

    localparam logic [NBITS-1:0] MAX_V = NBITS'(MAX_CNT);

    typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

    state_t           state, state_next;
    logic             sync1, sync2, dly;
    logic             rise, fall;
    logic [NBITS-1:0] cnt, hcnt;
    logic             cnt_start, cnt_inc, latch_h, report, tmo;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= iPWM;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign rise   = sync2 & ~dly;
    assign fall   = ~sync2 & dly;
    assign oLEVEL = sync2;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= ARM;
        else         state <= state_next;
    end

    // cnt holds the number of cycles since the last rise; reaching MAX_V without a rise is a timeout
    always_comb begin
        state_next = state;
        cnt_start  = 1'b0;
        cnt_inc    = 1'b0;
        latch_h    = 1'b0;
        report     = 1'b0;
        tmo        = 1'b0;
        case (state)
            ARM: begin
                if (rise) begin
                    cnt_start  = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (cnt == MAX_V) begin
                    tmo        = 1'b1;
                    state_next = ARM;
                end else if (fall) begin
                    latch_h    = 1'b1;
                    cnt_inc    = 1'b1;
                    state_next = LOW;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    report     = 1'b1;
                    cnt_start  = 1'b1;
                    state_next = HIGH;
                end else if (cnt == MAX_V) begin
                    tmo        = 1'b1;
                    state_next = ARM;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_next = ARM;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cnt      <= '0;
            hcnt     <= '0;
            oPERIOD  <= '0;
            oHIGH    <= '0;
            oVALID   <= 1'b0;
            oTIMEOUT <= 1'b0;
        end else begin
            oVALID <= report;
            if (cnt_start)    cnt <= NBITS'(1);
            else if (cnt_inc) cnt <= cnt + NBITS'(1);
            else if (tmo)     cnt <= '0;
            if (latch_h) hcnt <= cnt;
            if (report) begin
                oPERIOD  <= cnt;
                oHIGH    <= hcnt;
                oTIMEOUT <= 1'b0;
            end else if (tmo) begin
                oPERIOD  <= '0;
                oHIGH    <= '0;
                oTIMEOUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_meas.sv
// tb/tb_pwm_meas.sv - bench for pwm_meas with an edge-event reference model
module tb_pwm_meas;

    localparam int MAXC = 100;

    logic       iCLK;
    logic       iRST_n;
    logic       iPWM;
    logic [6:0] oPERIOD;
    logic [6:0] oHIGH;
    logic       oVALID;
    logic       oTIMEOUT;
    logic       oLEVEL;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_v = -1;
    int vcount = 0;
    int mixed = 0;
    bit started = 0;

    pwm_meas #(.SYSCLK_FRQ(1000), .freq_min(10)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iPWM(iPWM),
        .oPERIOD(oPERIOD), .oHIGH(oHIGH), .oVALID(oVALID),
        .oTIMEOUT(oTIMEOUT), .oLEVEL(oLEVEL)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model on the sampled-input timeline: a rise sampled at edge n is
    // reported two edges later; periods and high times are differences of edge indices.
    typedef struct packed {
        logic       val;
        logic       tmo;
        logic [6:0] per;
        logic [6:0] high;
    } obs_t;

    obs_t st1, st2, expv, cur;
    logic prev, exp_lvl;
    bit   armed;
    int   n, last_rise, last_fall;

    always @(posedge iCLK) begin
        if (!iRST_n) begin
            st1 = '0; st2 = '0; expv = '0; cur = '0;
            prev = 1'b0; exp_lvl = 1'b0; armed = 0;
            n = 0; last_rise = 0; last_fall = 0;
        end else begin
            cur.val = 1'b0;
            if (iPWM && !prev) begin
                if (armed) begin
                    cur.val  = 1'b1;
                    cur.per  = 7'(n - last_rise);
                    cur.high = 7'(last_fall - last_rise);
                    cur.tmo  = 1'b0;
                end
                armed     = 1;
                last_rise = n;
            end else if (armed && (n - last_rise) == MAXC) begin
                cur.tmo  = 1'b1;
                cur.per  = '0;
                cur.high = '0;
                armed    = 0;
            end
            if (!iPWM && prev) last_fall = n;
            expv    = st2;
            st2     = st1;
            st1     = cur;
            exp_lvl = prev;
            prev    = iPWM;
            n++;
        end
    end

    always @(negedge iCLK) begin
        if (started) begin
            if (!iRST_n) begin
                chk("rst_valid", oVALID, 0);
                chk("rst_period", oPERIOD, 0);
            end else begin
                chk("valid", oVALID, expv.val);
                chk("timeout", oTIMEOUT, expv.tmo);
                chk("period", oPERIOD, expv.per);
                chk("high", oHIGH, expv.high);
                chk("level", oLEVEL, exp_lvl);
            end
        end
        if (oVALID) begin
            vcount++;
            if (first_v < 0) first_v = cyc;
            if ((oPERIOD == 10 && oHIGH == 15) || (oPERIOD == 20 && oHIGH == 3)) mixed++;
        end
    end

    task automatic periods(input int p, input int h, input int num);
        for (int k = 0; k < num; k++) begin
            for (int i = 0; i < p; i++) begin
                @(posedge iCLK);
                #1;
                iPWM = (i < h);
                if (k == 0 && i == 0) start_cyc = cyc;
            end
        end
    endtask

    task automatic hold(input logic lvl, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge iCLK);
            #1;
            iPWM = lvl;
        end
    endtask

    initial begin
        iRST_n = 1'b0;
        iPWM   = 1'b0;
        repeat (3) @(posedge iCLK);
        started = 1;
        #1;
        chk("reset_period", oPERIOD, 0);
        chk("reset_timeout", oTIMEOUT, 0);
        chk("reset_level", oLEVEL, 0);
        iRST_n = 1'b1;

        // 1: steady P=10/H=3, first report 13 edges after the first driven high
        first_v = -1;
        periods(10, 3, 6);
        chk("t1_first_latency", first_v - start_cyc, 13);
        chk("t1_period", oPERIOD, 10);
        chk("t1_high", oHIGH, 3);

        // 2: toggle every cycle
        periods(2, 1, 5);
        vcount = 0;
        periods(2, 1, 5);
        chk("t2_valid_count", vcount, 5);
        chk("t2_period", oPERIOD, 2);
        chk("t2_high", oHIGH, 1);

        // 3: stuck low, stuck high, recovery
        vcount = 0;
        hold(1'b0, 110);
        chk("t3_tmo_low", oTIMEOUT, 1);
        chk("t3_level_low", oLEVEL, 0);
        chk("t3_period_zero", oPERIOD, 0);
        periods(10, 3, 4);
        hold(1'b1, 110);
        chk("t3_tmo_high", oTIMEOUT, 1);
        chk("t3_level_high", oLEVEL, 1);
        chk("t3_high_zero", oHIGH, 0);
        periods(10, 3, 4);
        chk("t3_tmo_cleared", oTIMEOUT, 0);
        chk("t3_recover_period", oPERIOD, 10);

        // 4: longest valid period, then one cycle too long
        periods(100, 50, 3);
        chk("t4_period_max", oPERIOD, 100);
        chk("t4_high_max", oHIGH, 50);
        chk("t4_no_tmo", oTIMEOUT, 0);
        periods(101, 50, 1);
        vcount = 0;
        periods(101, 50, 1);
        chk("t4_tmo_101", oTIMEOUT, 1);
        chk("t4_no_valid_101", vcount, 0);

        // 5: reset during the high phase
        periods(10, 3, 3);
        hold(1'b1, 2);
        @(posedge iCLK);
        #1;
        iRST_n = 1'b0;
        iPWM   = 1'b0;
        #1;
        chk("t5_rst_period", oPERIOD, 0);
        chk("t5_rst_high", oHIGH, 0);
        chk("t5_rst_level", oLEVEL, 0);
        repeat (2) @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
        vcount = 0;
        periods(10, 3, 1);
        chk("t5_no_early_valid", vcount, 0);
        periods(10, 3, 2);
        chk("t5_period", oPERIOD, 10);
        chk("t5_high", oHIGH, 3);

        // 6: switch at a rising edge
        periods(10, 3, 3);
        mixed = 0;
        periods(20, 15, 3);
        chk("t6_period", oPERIOD, 20);
        chk("t6_high", oHIGH, 15);
        chk("t6_no_mixed", mixed, 0);

        hold(1'b0, 3);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
